disp_mux_bcd: RTL

//  Time-multiplexed 4-digit 7-segment display driver. Consumer of the stopwatch
//  BCD digit bus (d3..d0): snapshots digits once per scan frame, decodes BCD to

---
 rtl/disp_mux_bcd_pkg.sv | 37 +++
 rtl/disp_mux_bcd_sseg.sv | 12 +
 rtl/disp_mux_bcd.sv | 89 ++++++++
 3 files changed

// File: rtl/disp_mux_bcd_pkg.sv
// Segment constants and BCD-to-7-segment helper shared by the display mux.
package disp_pkg;

  localparam logic [7:0] SEG_0    = 8'hC0;
  localparam logic [7:0] SEG_1    = 8'hF9;
  localparam logic [7:0] SEG_2    = 8'hA4;
  localparam logic [7:0] SEG_3    = 8'hB0;
  localparam logic [7:0] SEG_4    = 8'h99;
  localparam logic [7:0] SEG_5    = 8'h92;
  localparam logic [7:0] SEG_6    = 8'h82;
  localparam logic [7:0] SEG_7    = 8'hF8;
  localparam logic [7:0] SEG_8    = 8'h80;
  localparam logic [7:0] SEG_9    = 8'h90;
  localparam logic [7:0] SEG_DASH = 8'hBF;
  localparam logic [7:0] SEG_OFF  = 8'hFF;
  localparam logic [3:0] AN_OFF   = 4'hF;

  // Returns active-low {g,f,e,d,c,b,a}; non-BCD codes render as a dash.
  function automatic logic [6:0] bcd_to_seg7(input logic [3:0] bcd);
    logic [7:0] seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
    return seg[6:0];
  endfunction

endpackage

// File: rtl/disp_mux_bcd_sseg.sv
// Combinational decoder: BCD digit plus decimal-point request to active-low sseg.
module bcd_to_sseg
  import disp_pkg::*;
(
  input  logic [3:0] i_bcd,
  input  logic       i_dp,
  output logic [7:0] o_sseg
);

  assign o_sseg = {~i_dp, bcd_to_seg7(i_bcd)};

endmodule

// File: rtl/disp_mux_bcd.sv
// Time-multiplexed 4-digit 7-segment driver with per-frame digit snapshot.
// Optional leading-zero blanking of digits 3/2 when LEADING_ZERO_BLANK_EN is defined.
module disp_mux_bcd
  import disp_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d3,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  input  logic [3:0] dp_in,
  output logic [3:0] an,
  output logic [7:0] sseg,
  output logic       frame_tick
);

  localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_sel;
  logic [15:0]      r_snap_d;
  logic [3:0]       r_snap_dp;
  logic [3:0]       r_an;
  logic [7:0]       r_sseg;
  logic             r_frame_tick;

  logic             w_wrap;
  logic             w_load;
  logic [1:0]       w_sel_nxt;
  logic [15:0]      w_snap_d_nxt;
  logic [3:0]       w_snap_dp_nxt;
  logic [3:0]       w_digit;
  logic             w_dp_bit;
  logic [7:0]       w_sseg_dec;
  logic [3:0]       w_an_nxt;
  logic             w_blank;

  assign w_wrap        = (r_cnt == CNT_W'(REFRESH_DIV - 1));
  assign w_load        = w_wrap && (r_sel == 2'd3);
  assign w_sel_nxt     = w_wrap ? r_sel + 2'd1 : r_sel;
  assign w_snap_d_nxt  = w_load ? {d3, d2, d1, d0} : r_snap_d;
  assign w_snap_dp_nxt = w_load ? dp_in : r_snap_dp;

  // Outputs decode from next-state sel/snapshot so digit0 of a new frame already shows new data.
  assign w_digit  = w_snap_d_nxt[w_sel_nxt*4 +: 4];
  assign w_dp_bit = w_snap_dp_nxt[w_sel_nxt];
  assign w_an_nxt = ~(4'b0001 << w_sel_nxt);

  bcd_to_sseg u_dec (
    .i_bcd  (w_digit),
    .i_dp   (w_dp_bit),
    .o_sseg (w_sseg_dec)
  );

`ifdef LEADING_ZERO_BLANK_EN
  assign w_blank = ((w_sel_nxt == 2'd3) && (w_snap_d_nxt[15:12] == 4'd0)) ||
                   ((w_sel_nxt == 2'd2) && (w_snap_d_nxt[15:8] == 8'd0));
`else
  assign w_blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_sel        <= '0;
      r_snap_d     <= '0;
      r_snap_dp    <= '0;
      r_an         <= AN_OFF;
      r_sseg       <= SEG_OFF;
      r_frame_tick <= 1'b0;
    end else begin
      r_cnt        <= w_wrap ? '0 : r_cnt + 1'b1;
      r_sel        <= w_sel_nxt;
      r_snap_d     <= w_snap_d_nxt;
      r_snap_dp    <= w_snap_dp_nxt;
      r_an         <= w_blank ? AN_OFF  : w_an_nxt;
      r_sseg       <= w_blank ? SEG_OFF : w_sseg_dec;
      r_frame_tick <= w_load;
    end
  end

  assign an         = r_an;
  assign sseg       = r_sseg;
  assign frame_tick = r_frame_tick;

endmodule
